// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// RUN cycle on operand magnitudes, with sign correction applied in FIX.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Two's complement negate when n is set (operand width).
  function automatic logic [WIDTH-1:0] neg_if_w(input logic n, input logic [WIDTH-1:0] x);
    return n ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Two's complement negate when n is set (double width).
  function automatic logic [2*WIDTH-1:0] neg_if_2w(input logic n, input logic [2*WIDTH-1:0] x);
    return n ? (~x + {{(2*WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic               dz_r;
  logic               res_neg_r;   // product / quotient needs negation
  logic               rem_neg_r;   // remainder follows dividend sign
  logic [WIDTH-1:0]   opnd_r;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] p_r;         // {partial product | remainder, multiplier | quotient}

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_sub_s;
  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   hi_s;
  logic [WIDTH-1:0]   lo_s;

  // Operand sign and magnitude at acceptance; unsigned ops never negate.
  always_comb begin
    a_neg_s = ~op[0] & a[WIDTH-1];
    b_neg_s = ~op[0] & b[WIDTH-1];
    a_mag_s = neg_if_w(a_neg_s, a);
    b_mag_s = neg_if_w(b_neg_s, b);
  end

  // One iteration of shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    mul_sum_s = {1'b0, p_r[2*WIDTH-1:WIDTH]}
              + (p_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    // Partial remainder shifted left with the next dividend bit appended.
    div_ge_s  = (p_r[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_r});
    div_sub_s = p_r[2*WIDTH-2:WIDTH-1] - opnd_r;
    if (is_div_r) begin
      if (div_ge_s) begin
        step_s = {div_sub_s, p_r[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {p_r[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, p_r[WIDTH-1:1]};
    end
  end

  // Sign-corrected result presented to the HI/LO registers in FIX.
  always_comb begin
    prod_fix_s = neg_if_2w(res_neg_r, p_r);
    if (dz_r) begin
      hi_s = p_r[2*WIDTH-1:WIDTH];
      lo_s = p_r[WIDTH-1:0];
    end else if (is_div_r) begin
      hi_s = neg_if_w(rem_neg_r, p_r[2*WIDTH-1:WIDTH]);
      lo_s = neg_if_w(res_neg_r, p_r[WIDTH-1:0]);
    end else begin
      hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Control FSM, datapath state and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      dz_r      <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      opnd_r    <= {WIDTH{1'b0}};
      p_r       <= {(2*WIDTH){1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      if (flush) begin
        state_r <= IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              busy      <= 1'b1;
              cnt_r     <= {CW{1'b0}};
              is_div_r  <= op[1];
              res_neg_r <= a_neg_s ^ b_neg_s;
              rem_neg_r <= a_neg_s;
              dz_r      <= op[1] & (b == {WIDTH{1'b0}});
              if (op[1] && (b == {WIDTH{1'b0}})) begin
                // Divide by zero: result is fixed, go straight to FIX.
                p_r     <= {a, {WIDTH{1'b1}}};
                state_r <= FIX;
              end else if (op[1]) begin
                opnd_r  <= b_mag_s;
                p_r     <= {{WIDTH{1'b0}}, a_mag_s};
                state_r <= RUN;
              end else begin
                opnd_r  <= a_mag_s;
                p_r     <= {{WIDTH{1'b0}}, b_mag_s};
                state_r <= RUN;
              end
            end
          end
          RUN: begin
            p_r   <= step_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(WIDTH-1)) begin
              state_r <= FIX;
            end
          end
          FIX: begin
            hi       <= hi_s;
            lo       <= lo_s;
            div_zero <= dz_r;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed testbench for alu_muldiv (WIDTH=32).
module tb_alu_muldiv;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        flush = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  // Present an operation, let one edge accept it, then scramble the operands.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge CLK); #1;
    start = 1'b0; op = 2'b01; a = 32'hDEADBEEF; b = 32'h12345678;
  endtask

  // Count edges until done is seen, bounded at 100 cycles.
  task automatic wait_done(output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge CLK); #1;
      n++;
      seen = done;
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h want 0", hi); end
    tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h want 0", lo); end
    #21 RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_mult();
    logic [1:0]  t_op [5];
    logic [31:0] t_a [5], t_b [5], t_hi [5], t_lo [5];
    int n; bit seen;
    t_op[0]=2'b00; t_a[0]=32'hFFFFFFFF; t_b[0]=32'h00000002; t_hi[0]=32'hFFFFFFFF; t_lo[0]=32'hFFFFFFFE;
    t_op[1]=2'b01; t_a[1]=32'hFFFFFFFF; t_b[1]=32'h00000002; t_hi[1]=32'h00000001; t_lo[1]=32'hFFFFFFFE;
    t_op[2]=2'b00; t_a[2]=32'h00000003; t_b[2]=32'hFFFFFFFB; t_hi[2]=32'hFFFFFFFF; t_lo[2]=32'hFFFFFFF1;
    t_op[3]=2'b01; t_a[3]=32'hFFFFFFFF; t_b[3]=32'hFFFFFFFF; t_hi[3]=32'hFFFFFFFE; t_lo[3]=32'h00000001;
    t_op[4]=2'b00; t_a[4]=32'h80000000; t_b[4]=32'h80000000; t_hi[4]=32'h40000000; t_lo[4]=32'h00000000;
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mult_busy[%0d]: got %b want 1", i, busy); end
      wait_done(n, seen);
      tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL mult_latency[%0d]: got %0d want 33", i, n); end
      tests_run++; if (hi !== t_hi[i]) begin tests_failed++; $display("FAIL mult_hi[%0d]: got %h want %h", i, hi, t_hi[i]); end
      tests_run++; if (lo !== t_lo[i]) begin tests_failed++; $display("FAIL mult_lo[%0d]: got %h want %h", i, lo, t_lo[i]); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mult_busy_done[%0d]: got %b want 0", i, busy); end
    end
    @(posedge CLK); #1;
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mult_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_div();
    logic [1:0]  t_op [7];
    logic [31:0] t_a [7], t_b [7], t_hi [7], t_lo [7];
    int n; bit seen;
    t_op[0]=2'b10; t_a[0]=32'hFFFFFFF9; t_b[0]=32'h00000002; t_lo[0]=32'hFFFFFFFD; t_hi[0]=32'hFFFFFFFF;
    t_op[1]=2'b11; t_a[1]=32'h00000007; t_b[1]=32'h00000002; t_lo[1]=32'h00000003; t_hi[1]=32'h00000001;
    t_op[2]=2'b10; t_a[2]=32'h00000007; t_b[2]=32'hFFFFFFFE; t_lo[2]=32'hFFFFFFFD; t_hi[2]=32'h00000001;
    t_op[3]=2'b10; t_a[3]=32'hFFFFFFF9; t_b[3]=32'hFFFFFFFE; t_lo[3]=32'h00000003; t_hi[3]=32'hFFFFFFFF;
    t_op[4]=2'b11; t_a[4]=32'hFFFFFFFF; t_b[4]=32'h00000010; t_lo[4]=32'h0FFFFFFF; t_hi[4]=32'h0000000F;
    t_op[5]=2'b10; t_a[5]=32'h80000000; t_b[5]=32'hFFFFFFFF; t_lo[5]=32'h80000000; t_hi[5]=32'h00000000;
    t_op[6]=2'b11; t_a[6]=32'h00000005; t_b[6]=32'h00000009; t_lo[6]=32'h00000000; t_hi[6]=32'h00000005;
    for (int i = 0; i < 7; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(n, seen);
      tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL div_latency[%0d]: got %0d want 33", i, n); end
      tests_run++; if (lo !== t_lo[i]) begin tests_failed++; $display("FAIL div_lo[%0d]: got %h want %h", i, lo, t_lo[i]); end
      tests_run++; if (hi !== t_hi[i]) begin tests_failed++; $display("FAIL div_hi[%0d]: got %h want %h", i, hi, t_hi[i]); end
      tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL div_dz[%0d]: got %b want 0", i, div_zero); end
    end
  endtask

  task automatic test_div_zero();
    int n; bit seen;
    issue(2'b11, 32'h00000007, 32'h00000000);
    wait_done(n, seen);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL dz_latency: got %0d want 1", n); end
    tests_run++; if (lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL dz_lo: got %h want FFFFFFFF", lo); end
    tests_run++; if (hi !== 32'h00000007) begin tests_failed++; $display("FAIL dz_hi: got %h want 00000007", hi); end
    tests_run++; if (div_zero !== 1'b1) begin tests_failed++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    issue(2'b10, 32'hFFFFFFF9, 32'h00000000);
    wait_done(n, seen);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL dz_s_latency: got %0d want 1", n); end
    tests_run++; if (hi !== 32'hFFFFFFF9) begin tests_failed++; $display("FAIL dz_s_hi: got %h want FFFFFFF9", hi); end
    issue(2'b01, 32'h00000003, 32'h00000003);
    tests_run++; if (div_zero !== 1'b1) begin tests_failed++; $display("FAIL dz_hold: got %b want 1", div_zero); end
    wait_done(n, seen);
    tests_run++; if (lo !== 32'h00000009) begin tests_failed++; $display("FAIL dz_next_lo: got %h want 00000009", lo); end
    tests_run++; if (hi !== 32'h00000000) begin tests_failed++; $display("FAIL dz_next_hi: got %h want 00000000", hi); end
    tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL dz_clear: got %b want 0", div_zero); end
  endtask

  task automatic test_back_to_back();
    int n; bit seen;
    issue(2'b01, 32'h00000005, 32'h00000006);
    repeat (9) begin @(posedge CLK); #1; end
    start = 1'b1; op = 2'b11; a = 32'h00000064; b = 32'h00000003;
    @(posedge CLK); #1;
    start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_done(n, seen);
    tests_run++; if (n !== 23) begin tests_failed++; $display("FAIL b2b_ignored_latency: got %0d want 23", n); end
    tests_run++; if (lo !== 32'h0000001E) begin tests_failed++; $display("FAIL b2b_lo: got %h want 0000001E", lo); end
    tests_run++; if (hi !== 32'h00000000) begin tests_failed++; $display("FAIL b2b_hi: got %h want 00000000", hi); end
    issue(2'b01, 32'h00000007, 32'h00000008);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got %b want 1", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL b2b_single_done: got %b want 0", done); end
    wait_done(n, seen);
    tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL b2b_latency: got %0d want 33", n); end
    tests_run++; if (lo !== 32'h00000038) begin tests_failed++; $display("FAIL b2b_lo2: got %h want 00000038", lo); end
  endtask

  task automatic test_flush();
    int n; bit seen;
    issue(2'b01, 32'h0000FFFF, 32'h0000FFFF);
    repeat (4) begin @(posedge CLK); #1; end
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b want 0", busy); end
    wait_done(n, seen);
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_no_done: got %b want 0", seen); end
    tests_run++; if (lo !== 32'h00000038) begin tests_failed++; $display("FAIL flush_lo: got %h want 00000038", lo); end
    tests_run++; if (hi !== 32'h00000000) begin tests_failed++; $display("FAIL flush_hi: got %h want 00000000", hi); end
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'h2; b = 32'h2;
    @(posedge CLK); #1;
    start = 1'b0; flush = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_priority: got %b want 0", busy); end
    issue(2'b11, 32'h00000007, 32'h00000002);
    wait_done(n, seen);
    tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL flush_recover_latency: got %0d want 33", n); end
    tests_run++; if (lo !== 32'h00000003) begin tests_failed++; $display("FAIL flush_recover_lo: got %h want 00000003", lo); end
  endtask

  task automatic test_rst_mid();
    int n; bit seen;
    issue(2'b01, 32'h00000009, 32'h00000009);
    repeat (5) begin @(posedge CLK); #1; end
    #3 RST = 1'b1;
    #1;
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL rst_hi: got %h want 0", hi); end
    tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL rst_lo: got %h want 0", lo); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    wait_done(n, seen);
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL rst_no_done: got %b want 0", seen); end
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    issue(2'b11, 32'h00000007, 32'h00000002);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_first_accept: got %b want 1", busy); end
    wait_done(n, seen);
    tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL rst_after_latency: got %0d want 33", n); end
    tests_run++; if (lo !== 32'h00000003) begin tests_failed++; $display("FAIL rst_after_lo: got %h want 00000003", lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
